// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: ID-stage load-use/RAW hazard detection, EX/MEM operand forwarding,
// jump/branch flush sequencing and a saturating bubble counter for the 5-stage MIPS pipeline.
module hazard_ctrl_unit #(
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned LD_STALL  = 1,
   parameter int unsigned RAW_STALL = 2,
   parameter int unsigned BR_DELAY  = 1,
   parameter bit          FWD_EN    = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              jump,
   input  logic              branch,
   input  logic              alu_zero,
   input  logic              use_rs,
   input  logic              use_rt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              ex_wr,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic              mem_wr,
   input  logic [REG_AW-1:0] mem_dst,
   output logic              if_write,
   output logic              pc_write,
   output logic              bubble,
   output logic [1:0]        addr_sel,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] LdInit  = CW'(LD_STALL - 1);
   localparam logic [CW-1:0] RawInit = CW'(RAW_STALL - 1);
   localparam logic [CW-1:0] BrInit  = CW'(BR_DELAY - 1);

   typedef enum logic [2:0] {
      NORMAL   = 3'd0,
      JUMP     = 3'd1,
      BR_WAIT  = 3'd2,
      BR_TAKEN = 3'd3,
      STALL    = 3'd4
   } stateT;

   stateT         state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic          stateLegal;

   logic rsEx, rtEx, rsMem, rtMem, exHit, ldHz, rawHz;

   // Register match terms; $0 never creates a dependency
   assign rsEx  = use_rs && (ex_dst  != '0) && (id_rs == ex_dst);
   assign rtEx  = use_rt && (ex_dst  != '0) && (id_rt == ex_dst);
   assign rsMem = use_rs && (mem_dst != '0) && (id_rs == mem_dst);
   assign rtMem = use_rt && (mem_dst != '0) && (id_rt == mem_dst);
   assign exHit = ex_wr && (rsEx || rtEx);
   assign ldHz  = ex_mem_read && exHit;
   assign rawHz = !FWD_EN && !ex_mem_read && exHit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= NORMAL;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Next state and pipeline control; reset and illegal states fall back to a safe bubble
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      if_write   = 1'b0;
      pc_write   = 1'b0;
      bubble     = 1'b1;
      addr_sel   = 2'b00;
      stateLegal = 1'b1;
      case (state)
         NORMAL: begin
            if (jump) begin
               pc_write  = 1'b1;
               bubble    = 1'b0;
               addr_sel  = 2'b01;
               stateNext = JUMP;
            end else if (ldHz) begin
               if (LD_STALL > 1) begin
                  stateNext = STALL;
                  cntNext   = LdInit;
               end
            end else if (rawHz) begin
               if (RAW_STALL > 1) begin
                  stateNext = STALL;
                  cntNext   = RawInit;
               end
            end else if (branch) begin
               bubble    = 1'b0;
               stateNext = BR_WAIT;
               cntNext   = BrInit;
            end else begin
               if_write = 1'b1;
               pc_write = 1'b1;
               bubble   = 1'b0;
            end
         end
         JUMP, BR_TAKEN: begin
            if_write  = 1'b1;
            pc_write  = 1'b1;
            stateNext = NORMAL;
         end
         STALL: begin
            cntNext = cnt - CW'(1);
            if (cnt <= CW'(1)) stateNext = NORMAL;
         end
         BR_WAIT: begin
            if (cnt != '0) begin
               cntNext = cnt - CW'(1);
            end else if (alu_zero) begin
               pc_write  = 1'b1;
               addr_sel  = 2'b10;
               stateNext = BR_TAKEN;
            end else begin
               if_write  = 1'b1;
               pc_write  = 1'b1;
               stateNext = NORMAL;
            end
         end
         default: begin
            stateLegal = 1'b0;
            stateNext  = NORMAL;
            cntNext    = '0;
         end
      endcase
      if (!reset) begin
         if_write   = 1'b0;
         pc_write   = 1'b0;
         bubble     = 1'b1;
         addr_sel   = 2'b00;
         stateLegal = 1'b0;
      end
   end

   // Operand forwarding: EX result beats MEM result; a load in EX cannot be forwarded yet
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (FWD_EN && stateLegal && !ldHz) begin
         if (ex_wr && !ex_mem_read && rsEx) fwd_a = 2'b01;
         else if (mem_wr && rsMem)          fwd_a = 2'b10;
         if (ex_wr && !ex_mem_read && rtEx) fwd_b = 2'b01;
         else if (mem_wr && rtMem)          fwd_b = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (bubble && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
